niossoc_pio_ctrl: RTL and testbench
===================================

Name: niossoc_pio_ctrl

Overview:
- Parametrised next-generation Avalon-MM PIO slave for the NIOS SoC.
- Generalises the fixed 32-bit output-only register to a WIDTH-bit bidirectional port with per-bit direction, atomic set/clear, input synchronisation, edge capture and a maskable interrupt.
- Sits on the NIOS data master interconnect, with an irq line routed to the CPU interrupt controller.

Parameters:
- WIDTH, 32: port width in bits (1..32).
- RESET_VALUE, 0: reset value of the output data register (WIDTH bits).
- DIR_RESET, 0: reset value of the direction register; bit = 1 means output.
- EDGE_TYPE, 0: edge-capture sensitivity. 0 = rising, 1 = falling, 2 = any.
- IRQ_TYPE, 2: 0 = no irq (held 0), 1 = level, 2 = edge.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word offset
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH ignored
- readdata  out  32  read data; zero-extended above WIDTH
- in_port  in  WIDTH  asynchronous pin inputs
- out_port  out  WIDTH  output data register
- oe  out  WIDTH  direction register (per-bit output enable)
- irq  out  1  interrupt request, active high

Behaviour:
- One clock domain. reset_n asserts asynchronously; deassertion is handled by the system reset synchroniser.
- Reset values: data_out = RESET_VALUE, dir = DIR_RESET, mask = 0, edge_cap = 0, sync flops = 0, irq = 0.
- Write strobe: chipselect && !write_n. Register updates on the next clk edge.
- Register map:
  - 0 DATA: write loads data_out. Read returns (data_out & dir) | (in_sync & ~dir).
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: write-1-to-clear per bit; read returns edge_cap.
  - 4 OUTSET: write sets data_out |= wd. Reads 0.
  - 5 OUTCLR: write sets data_out &= ~wd. Reads 0.
  - 6, 7: reserved; writes ignored, reads 0.
- Reads are zero wait-state and combinational from registered state. No read side effects.
- Input path:
  - in_port passes through a 2-flop synchroniser to give in_sync.
  - A third flop holds in_prev.
  - A pin change at edge N is visible in DATA reads after edge N+2.
- Edge detect per bit:
  - rise = in_sync & ~in_prev; fall = ~in_sync & in_prev.
  - The active event (rise, fall, or either, per EDGE_TYPE) sets the edge_cap bit on the clock edge after it is detected, i.e. edge N+3 for a pin change at edge N.
  - Only bits with dir = 0 capture. Output bits never set edge_cap.
  - Set and write-1-clear on the same bit in the same cycle: set wins and the bit stays 1.
  - Writing 0 bits to EDGECAP leaves them unchanged.
- irq, computed combinationally from registers:
  - Level mode: |(in_sync & ~dir & mask).
  - Edge mode: |(edge_cap & mask).
  - IRQ_TYPE = 0 ties irq to 0.
  - Clearing the last masked edge_cap bit drops irq the cycle after the write.
  - Masking a pending bit drops irq without clearing edge_cap; unmasking it re-asserts irq.
- Changing DIR:
  - Does not alter data_out.
  - A bit switched to input may capture an edge on following cycles if in_sync differs from in_prev.
- Reset mid-operation clears all state immediately, including a pending irq. Edges in flight in the synchroniser are lost.
- out_port = data_out and oe = dir. No combinational path from the bus to the pins.

Test Plan:
- Reset: reset_n low for 3 cycles with default parameters -> out_port = 0, oe = 0, irq = 0, reads at addresses 0..7 return 0 (in_port = 0).
- Atomic set/clear: write DATA = 0x0000_00F0, then OUTSET 0x0F, then OUTCLR 0x30 -> out_port = 0xF0, then 0xFF, then 0xCF; reads of addresses 4 and 5 return 0.
- Direction mux: DIR = 0x0000_FFFF, DATA = 0x1234_5678, in_port = 0xABCD_0000 -> after 2 cycles DATA read = 0xABCD_5678 and oe = 0x0000_FFFF.
- Rising-edge capture and irq (EDGE_TYPE = 0, IRQ_TYPE = 2): mask = 0x1, in_port[0] 0->1 at edge N -> edge_cap[0] = 1 and irq = 1 from edge N+3. Write 0x1 to EDGECAP -> irq = 0 the next cycle.
- Set beats clear: arrange the write-1-clear of bit 0 on the same cycle a new rising edge is detected on bit 0 -> edge_cap[0] stays 1 and irq stays 1.
- Level irq (IRQ_TYPE = 1, WIDTH = 8): mask = 0x80, in_port = 0x80 -> irq high 2 cycles later. Set dir[7] = 1 -> irq drops the cycle after the write. writedata upper bits 0xFFFF_FF00 ignored, readdata[31:8] = 0.

Source files
------------

// File: rtl/niossoc_pio_ctrl.sv
// niossoc_pio_ctrl: parametrised Avalon-MM PIO slave with per-bit direction, set/clear, edge capture and maskable irq
//   clk, reset_n                          : clock, asynchronous active-low reset
//   address, chipselect, write_n, writedata, readdata : Avalon-MM slave, zero wait-state reads
//   in_port                               : asynchronous pin inputs (synchronised internally)
//   out_port, oe                          : output data register and per-bit output enable
//   irq                                   : interrupt request, active high
module niossoc_pio_ctrl #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          IRQ_TYPE    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);
  logic [WIDTH-1:0] data_out, dir, mask, edge_cap, sync0, in_sync, in_prev, wd, evt, clr, rd;
  logic wr;
  assign wr = chipselect && !write_n;
  assign wd = writedata[WIDTH-1:0];
  // only input bits capture; EDGE_TYPE 2 captures any change
  assign evt = (EDGE_TYPE == 0 ? in_sync & ~in_prev :
                EDGE_TYPE == 1 ? ~in_sync & in_prev : in_sync ^ in_prev) & ~dir;
  assign clr = (wr && address == 3'd3) ? wd : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_out <= RESET_VALUE[WIDTH-1:0];
      dir      <= DIR_RESET[WIDTH-1:0];
      mask     <= '0;
      edge_cap <= '0;
      sync0    <= '0;
      in_sync  <= '0;
      in_prev  <= '0;
    end else begin
      sync0    <= in_port;
      in_sync  <= sync0;
      in_prev  <= in_sync;
      edge_cap <= (edge_cap & ~clr) | evt;
      data_out <= !wr              ? data_out :
                  address == 3'd0  ? wd :
                  address == 3'd4  ? data_out | wd :
                  address == 3'd5  ? data_out & ~wd : data_out;
      dir      <= (wr && address == 3'd1) ? wd : dir;
      mask     <= (wr && address == 3'd2) ? wd : mask;
    end
  always_comb begin
    rd = address == 3'd0 ? (data_out & dir) | (in_sync & ~dir) :
         address == 3'd1 ? dir :
         address == 3'd2 ? mask :
         address == 3'd3 ? edge_cap : '0;
  end
  assign readdata = 32'(rd);
  assign out_port = data_out;
  assign oe       = dir;
  assign irq      = IRQ_TYPE == 1 ? |(in_sync & ~dir & mask) :
                    IRQ_TYPE == 2 ? |(edge_cap & mask) : 1'b0;
  if (WIDTH < 32) begin : g_pad
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end
endmodule

// File: tb/tb_niossoc_pio_ctrl.sv
// tb_niossoc_pio_ctrl: directed table-driven bench for niossoc_pio_ctrl (32-bit edge irq and 8-bit level irq instances)
module tb_niossoc_pio_ctrl;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [2:0]  address = '0;
  logic        chipselect = 0;
  logic        write_n = 1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata, readdata2;
  logic [31:0] in_port = '0, out_port, oe;
  logic [7:0]  in_port2 = '0, out_port2, oe2;
  logic        irq, irq2;
  int checks = 0, errors = 0;

  always #10 clk = ~clk;

  niossoc_pio_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq));

  niossoc_pio_ctrl #(.WIDTH(8), .IRQ_TYPE(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2),
    .in_port(in_port2), .out_port(out_port2), .oe(oe2), .irq(irq2));

  typedef struct {
    logic [2:0]  wa;
    logic [31:0] wd, pin;
    logic [2:0]  ra;
    logic [31:0] eout, eoe, erd;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(posedge clk);
    #1;
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v, output logic [31:0] v2);
    address = a;
    #1;
    v = readdata;
    v2 = readdata2;
  endtask

  initial begin
    logic [31:0] v, v2;
    tv[0] = '{3'd0, 32'h0000_00F0, 32'h0,         3'd0, 32'h0000_00F0, 32'h0,         32'h0};
    tv[1] = '{3'd4, 32'h0000_000F, 32'h0,         3'd4, 32'h0000_00FF, 32'h0,         32'h0};
    tv[2] = '{3'd5, 32'h0000_0030, 32'h0,         3'd5, 32'h0000_00CF, 32'h0,         32'h0};
    tv[3] = '{3'd1, 32'h0000_FFFF, 32'h0,         3'd1, 32'h0000_00CF, 32'h0000_FFFF, 32'h0000_FFFF};
    tv[4] = '{3'd0, 32'h1234_5678, 32'hABCD_0000, 3'd0, 32'h1234_5678, 32'h0000_FFFF, 32'hABCD_5678};
    tv[5] = '{3'd6, 32'hDEAD_BEEF, 32'hABCD_0000, 3'd3, 32'h1234_5678, 32'h0000_FFFF, 32'hABCD_0000};
    tv[6] = '{3'd3, 32'hFFFF_FFFF, 32'hABCD_0000, 3'd3, 32'h1234_5678, 32'h0000_FFFF, 32'h0};
    tv[7] = '{3'd7, 32'h0000_0001, 32'hABCD_0000, 3'd7, 32'h1234_5678, 32'h0000_FFFF, 32'h0};
    tv[8] = '{3'd1, 32'hFFFF_0000, 32'hABCD_0000, 3'd0, 32'h1234_5678, 32'hFFFF_0000, 32'h1234_0000};
    tv[9] = '{3'd2, 32'h0000_0001, 32'hABCD_0000, 3'd2, 32'h1234_5678, 32'hFFFF_0000, 32'h0000_0001};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out_port, 32'h0);
    chk("rst_oe", oe, 32'h0);
    chk("rst_irq", irq, 0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v, v2);
      chk($sformatf("rst_rd%0d", a), v, 32'h0);
    end
    reset_n = 1;
    step(1);

    for (int i = 0; i < 10; i++) begin
      in_port = tv[i].pin;
      bus_write(tv[i].wa, tv[i].wd);
      step(2);
      chk($sformatf("v%0d_out", i), out_port, tv[i].eout);
      chk($sformatf("v%0d_oe", i), oe, tv[i].eoe);
      rd(tv[i].ra, v, v2);
      chk($sformatf("v%0d_rd", i), v, tv[i].erd);
    end
    chk("tbl_irq", irq, 0);

    in_port = 32'hABCD_0001;
    step(1); chk("rise_n1_irq", irq, 0);
    step(1); chk("rise_n2_irq", irq, 0);
    rd(3, v, v2); chk("rise_n2_cap", v, 32'h0);
    step(1); chk("rise_n3_irq", irq, 1);
    rd(3, v, v2); chk("rise_n3_cap", v, 32'h1);
    bus_write(3, 32'h1);
    chk("clr_irq", irq, 0);
    rd(3, v, v2); chk("clr_cap", v, 32'h0);

    in_port = 32'hABCD_0000;
    step(4);
    rd(3, v, v2); chk("fall_ignored_cap", v, 32'h0);
    chk("fall_ignored_irq", irq, 0);
    in_port = 32'hABCD_0001;
    step(3);
    rd(3, v, v2); chk("recap_cap", v, 32'h1);

    in_port = 32'hABCD_0000;
    step(3);
    in_port = 32'hABCD_0001;
    step(2);
    bus_write(3, 32'h1);
    rd(3, v, v2); chk("setwins_cap", v, 32'h1);
    chk("setwins_irq", irq, 1);

    bus_write(2, 32'h0);
    chk("masked_irq", irq, 0);
    rd(3, v, v2); chk("masked_cap", v, 32'h1);
    bus_write(2, 32'h1);
    chk("unmasked_irq", irq, 1);

    reset_n = 0;
    #1;
    chk("midrst_irq", irq, 0);
    chk("midrst_out", out_port, 32'h0);
    chk("midrst_oe", oe, 32'h0);
    in_port = '0;
    step(3);
    reset_n = 1;
    step(1);

    bus_write(2, 32'hFFFF_FF80);
    rd(2, v, v2); chk("lvl_mask_rd", v2, 32'h0000_0080);
    in_port2 = 8'h80;
    step(1); chk("lvl_n1_irq", irq2, 0);
    step(1); chk("lvl_n2_irq", irq2, 1);
    bus_write(1, 32'hFFFF_FF80);
    chk("lvl_dir_irq", irq2, 0);
    chk("lvl_oe", oe2, 8'h80);
    rd(1, v, v2); chk("lvl_dir_rd", v2, 32'h0000_0080);
    rd(0, v, v2); chk("lvl_data_rd", v2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
